// File: rtl/plot_sink_pkg.sv
// ============================================================================
//  Module  : plot_pkg (package)
//  Purpose : Shared screen geometry, FSM state encoding and pixel record for
//            the plot sink and its FIFO.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package plot_pkg;

  // Screen geometry of the 160x120 framebuffer
  localparam int X_MAX         = 160;
  localparam int Y_MAX         = 120;
  localparam int ADDR_W        = 15;
  localparam int SCREEN_PIXELS = X_MAX * Y_MAX;

  // Write-side FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } plot_state_t;

  // One queued plot request
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] color;
  } pixel_t;

endpackage

`default_nettype wire

// File: rtl/plot_sink_if.sv
// ============================================================================
//  Module  : plot_sink_if
//  Purpose : Plot stream in, framebuffer write port out, plus status.
//            'master' is the game/memory side, 'slave' is the plot sink.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface plot_sink_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 15
);

  // Plot stream from the game datapath
  logic [7:0]            x;
  logic [7:0]            y;
  logic [2:0]            color;
  logic                  plot;
  logic                  clear;

  // Framebuffer write port
  logic [ADDR_W-1:0]     mem_addr;
  logic [2:0]            mem_data;
  logic                  mem_we;
  logic                  mem_ready;

  // Status
  logic                  busy;
  logic                  overflow;
  logic [$clog2(DEPTH):0] level;

  modport master (
    output x, y, color, plot, clear, mem_ready,
    input  mem_addr, mem_data, mem_we, busy, overflow, level
  );

  modport slave (
    input  x, y, color, plot, clear, mem_ready,
    output mem_addr, mem_data, mem_we, busy, overflow, level
  );

endinterface

`default_nettype wire

// File: rtl/plot_sink_fifo.sv
// ============================================================================
//  Module  : pixel_fifo
//  Purpose : Synchronous FIFO of pixel_t records. Exposes the head entry and
//            the entry behind it so the consumer can present back-to-back
//            writes from registered outputs. A push while full is accepted
//            only when a pop happens in the same cycle.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  pixel_t                 din_i,
  output pixel_t                 head_o,
  output pixel_t                 next_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  pixel_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [AW:0]     cnt_q;
  logic [AW-1:0]   w_next_idx;
  logic            w_push;
  logic            w_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == FULL_CNT);
  assign level_o    = cnt_q;
  assign w_pop      = pop_i && !empty_o;
  assign w_push     = push_i && (!full_o || w_pop);
  assign w_next_idx = rd_q + 1'b1;
  assign head_o     = mem_q[rd_q];
  assign next_o     = mem_q[w_next_idx];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/plot_sink.sv
// ============================================================================
//  Module  : plot_sink
//  Purpose : Turns the x/y/color/plot stream into single-port framebuffer
//            writes through a small FIFO, and performs full-screen clear
//            sweeps on request. Write outputs are registered and held while
//            the memory withholds mem_ready.
//  Config  : PLOT_CLIP_EN - when defined, off-screen plots are discarded at
//            the input (not queued, no overflow). Otherwise every plot is
//            queued and its address wraps to ADDR_W bits.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module plot_sink
  import plot_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int X_MAX  = plot_pkg::X_MAX,
  parameter int Y_MAX  = plot_pkg::Y_MAX,
  parameter int ADDR_W = plot_pkg::ADDR_W
) (
  input  logic      clk,
  input  logic      reset_n,
  plot_sink_if.slave bus
);

  localparam int                LW        = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(X_MAX * Y_MAX - 1);

  plot_state_t       state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        data_q, data_d;
  logic              clr_pend_q;
  logic [2:0]        clr_color_q;
  logic              overflow_q;
  logic              w_sweep_start;

  pixel_t            w_din;
  pixel_t            w_head;
  pixel_t            w_next;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic              w_in_range;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;

  // Linear framebuffer address, wrapped to the port width
  function automatic logic [ADDR_W-1:0] pix_addr(input pixel_t p);
    return ADDR_W'(32'(p.y) * 32'(X_MAX) + 32'(p.x));
  endfunction

  assign w_din = {bus.x, bus.y, bus.color};

`ifdef PLOT_CLIP_EN
  assign w_in_range = (32'(bus.x) < 32'(X_MAX)) && (32'(bus.y) < 32'(Y_MAX));
`else
  assign w_in_range = 1'b1;
`endif

  // In DRAIN the write request is always up, so ready alone means accepted
  assign w_pop  = (state_q == DRAIN) && bus.mem_ready;
  assign w_push = bus.plot && w_in_range;
  assign w_drop = w_push && w_full && !w_pop;

  pixel_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_din),
    .head_o  (w_head),
    .next_o  (w_next),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // State and registered write-port outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next state and next write request; the sweep address lives in addr_q
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    data_d        = data_q;
    w_sweep_start = 1'b0;
    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (clr_pend_q && w_empty) begin
          state_d       = CLEAR;
          we_d          = 1'b1;
          addr_d        = '0;
          data_d        = clr_color_q;
          w_sweep_start = 1'b1;
        end else if (!w_empty) begin
          state_d = DRAIN;
          we_d    = 1'b1;
          addr_d  = pix_addr(w_head);
          data_d  = w_head.color;
        end
      end
      DRAIN: begin
        if (bus.mem_ready) begin
          if (w_level > LW'(1)) begin
            // Head is popped this cycle; the entry behind it goes out next
            addr_d = pix_addr(w_next);
            data_d = w_next.color;
          end else begin
            state_d = IDLE;
            we_d    = 1'b0;
          end
        end
      end
      CLEAR: begin
        if (bus.mem_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
            we_d    = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  // Clear request latch; a new request wins over the sweep consuming the old
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clr_pend_q  <= 1'b0;
      clr_color_q <= '0;
    end else begin
      if (bus.clear) begin
        clr_pend_q  <= 1'b1;
        clr_color_q <= bus.color;
      end else if (w_sweep_start) begin
        clr_pend_q  <= 1'b0;
      end
    end
  end

  // Sticky overflow flag for plots lost to a full FIFO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (w_drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign bus.overflow = overflow_q;
  assign bus.level    = w_level;
  assign bus.busy     = (state_q != IDLE) || !w_empty || clr_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_plot_sink.sv
// ============================================================================
//  Module  : tb_plot_sink
//  Purpose : Directed self-checking bench for plot_sink.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_plot_sink;

  logic clk;
  logic reset_n;

  plot_sink_if #(.DEPTH(8), .ADDR_W(15)) bus ();

  plot_sink #(
    .DEPTH  (8),
    .X_MAX  (160),
    .Y_MAX  (120),
    .ADDR_W (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  c;
    logic        exp_we;
    logic [14:0] exp_addr;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [14:0] a;
    logic [2:0]  d;
  } wr_t;

  vec_t vt[6];
  wr_t  wlog[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Accepted-write log, taken from pre-edge register values
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && bus.mem_we && bus.mem_ready)
      wlog.push_back('{cyc: cyc, a: bus.mem_addr, d: bus.mem_data});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int errs;
    int n;
    bit found;

    // {x, y, color, write expected, address}
    vt[0] = '{8'd10,  8'd5,   3'd3, 1'b1, 15'd810};
    vt[1] = '{8'd0,   8'd0,   3'd1, 1'b1, 15'd0};
    vt[2] = '{8'd159, 8'd119, 3'd7, 1'b1, 15'd19199};
    vt[3] = '{8'd160, 8'd0,   3'd2, 1'b1, 15'd160};
    vt[4] = '{8'd255, 8'd255, 3'd6, 1'b1, 15'd8287};   // 41055 mod 32768
    vt[5] = '{8'd3,   8'd2,   3'd4, 1'b1, 15'd323};
`ifdef PLOT_CLIP_EN
    vt[3].exp_we = 1'b0;
    vt[4].exp_we = 1'b0;
`endif

    reset_n       = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.color     = '0;
    bus.plot      = 1'b0;
    bus.clear     = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) tick();

    chk("rst_addr",     32'(bus.mem_addr), 0);
    chk("rst_data",     32'(bus.mem_data), 0);
    chk("rst_we",       32'(bus.mem_we),   0);
    chk("rst_busy",     32'(bus.busy),     0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_level",    32'(bus.level),    0);
    reset_n = 1'b1;

    // Single plots: write appears two cycles after the strobe
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.x = vt[i].x; bus.y = vt[i].y; bus.color = vt[i].c; bus.plot = 1'b1;
      tick();
      bus.plot = 1'b0;
      chk("lat_we_c1", 32'(bus.mem_we), 0);
      tick();
      chk("vec_we", 32'(bus.mem_we), 32'(vt[i].exp_we));
      if (vt[i].exp_we) begin
        chk("vec_addr", 32'(bus.mem_addr), 32'(vt[i].exp_addr));
        chk("vec_data", 32'(bus.mem_data), 32'(vt[i].c));
      end
      tick();
      tick();
      chk("vec_busy_c4", 32'(bus.busy),     0);
      chk("vec_overflow", 32'(bus.overflow), 0);
    end

    // Back-pressure: three plots, memory stalled for five cycles
    wlog.delete();
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      bus.x = 8'(i); bus.y = 8'(i); bus.color = (i == 3) ? 3'd4 : 3'(i); bus.plot = 1'b1;
    end
    tick();
    bus.plot = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_we",   32'(bus.mem_we),   1);
      chk("bp_hold_addr", 32'(bus.mem_addr), 161);
      chk("bp_hold_data", 32'(bus.mem_data), 1);
    end
    bus.mem_ready = 1'b1;
    repeat (6) tick();
    chk("bp_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("bp_addr0", 32'(wlog[0].a), 161);
      chk("bp_addr1", 32'(wlog[1].a), 322);
      chk("bp_addr2", 32'(wlog[2].a), 483);
      chk("bp_data2", 32'(wlog[2].d), 4);
      chk("bp_consec", 32'(wlog[2].cyc - wlog[0].cyc), 2);
    end

    // Overflow: ten plots into an 8-deep FIFO with memory stalled
    wlog.delete();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.x = 8'(20 + i); bus.y = 8'd1; bus.color = 3'(i); bus.plot = 1'b1;
    end
    tick();
    bus.plot = 1'b0;
    tick();
    chk("ovf_level", 32'(bus.level),    8);
    chk("ovf_flag",  32'(bus.overflow), 1);
    bus.mem_ready = 1'b1;
    repeat (14) tick();
    chk("ovf_count", wlog.size(), 8);
    errs = 0;
    for (int i = 0; i < 8; i++)
      if (i >= wlog.size() || wlog[i].a != 15'(180 + i) || wlog[i].d != 3'(i)) errs++;
    chk("ovf_order", errs, 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    do_reset();
    tick();
    chk("ovf_cleared", 32'(bus.overflow), 0);

    // Full-screen clear with a plot arriving mid-sweep
    wlog.delete();
    tick();
    bus.color = 3'd5; bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (1000) tick();
    bus.x = 8'd7; bus.y = 8'd3; bus.color = 3'd2; bus.plot = 1'b1;
    tick();
    bus.plot = 1'b0;
    for (int i = 0; i < 25000 && bus.busy; i++) tick();
    chk("clr_done_busy", 32'(bus.busy), 0);
    chk("clr_count", wlog.size(), 19201);
    errs = 0;
    if (wlog.size() >= 19201) begin
      for (int i = 0; i < 19200; i++)
        if (wlog[i].a != 15'(i) || wlog[i].d != 3'd5) errs++;
      chk("clr_tail_addr", 32'(wlog[19200].a), 487);
      chk("clr_tail_data", 32'(wlog[19200].d), 2);
      chk("clr_consec", 32'(wlog[19199].cyc - wlog[0].cyc), 19199);
    end else begin
      errs = 19200;
    end
    chk("clr_sweep", errs, 0);

    // Reset in the middle of a sweep with a plot queued behind it
    tick();
    bus.color = 3'd6; bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.x = 8'd1; bus.y = 8'd0; bus.plot = 1'b1;
    tick();
    bus.plot = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.mem_we && bus.mem_addr == 15'd100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_reach_100", 32'(found), 1);
    chk("mid_level_pre", 32'(bus.level), 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_we",    32'(bus.mem_we), 0);
    chk("mid_rst_level", 32'(bus.level),  0);
    chk("mid_rst_busy",  32'(bus.busy),   0);
    reset_n = 1'b1;
    n = wlog.size();
    repeat (50) tick();
    chk("mid_no_writes", wlog.size() - n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/plot_sink.md
# plot_sink

Receiving end of the game's pixel-plot interface: accepts the `x`/`y`/`color`/`plot` stream from the datapath mux and FSM, and turns it into single-port framebuffer writes. Plot strobes are buffered in a small FIFO so that memory back-pressure never stalls the game FSM. The block also performs a full-screen clear sweep on request. It sits between the game top and the 160×120, 3-bit-colour video memory.

## Interface
- `DEPTH`, 8: FIFO entries (power of two, ≥2)
- `X_MAX`, 160: screen width in pixels
- `Y_MAX`, 120: screen height in pixels
- `ADDR_W`, 15: framebuffer address width
- `clk` in 1: system clock; all logic is on the rising edge
- `reset_n` in 1: synchronous, active-low reset
- `x` in 8: pixel column
- `y` in 8: pixel row
- `color` in 3: pixel colour; also the fill colour on `clear`
- `plot` in 1: one-cycle write strobe, enqueues {x,y,color}
- `clear` in 1: one-cycle request for a full-screen fill with `color`
- `mem_addr` out ADDR_W: framebuffer write address
- `mem_data` out 3: framebuffer write data
- `mem_we` out 1: write request; held until accepted
- `mem_ready` in 1: memory accepts the write this cycle when high with `mem_we`
- `busy` out 1: high when the FSM is not IDLE, the FIFO is non-empty, or a clear is pending
- `overflow` out 1: sticky; set when a plot is dropped because the FIFO is full
- `level` out $clog2(DEPTH)+1: current FIFO occupancy

## Operation
- Address computation: `mem_addr = y*X_MAX + x`, computed at dequeue and truncated to ADDR_W.
- FSM states:
  - IDLE: `mem_we`=0. Go to CLEAR if a clear is pending and the FIFO is empty. Otherwise go to DRAIN if the FIFO is non-empty.
  - DRAIN: present the head entry with `mem_we`=1. On `mem_ready`, pop the entry. After the last pop, go to IDLE.
  - CLEAR: sweep addresses 0..X_MAX*Y_MAX−1 (0..19199) with `mem_data` equal to the latched clear colour. Advance one address per accepted write. After the final address is accepted, return to IDLE.
- Clear handling:
  - A `clear` pulse latches `color` into the clear-colour register and sets `clear_pending`.
  - Previously queued plots are drained first.
  - Plots arriving during CLEAR are enqueued but not written until the sweep ends.
  - A second `clear` during CLEAR re-latches the colour and re-arms `clear_pending`, which starts a new sweep after the current one.
- FIFO full:
  - A `plot` while `level==DEPTH` and no pop in the same cycle is dropped and sets `overflow`.
  - A `plot` with a simultaneous pop is accepted.
- `plot` and `clear` in the same cycle: both take effect. The plot is enqueued before the clear, so it is overwritten by the sweep.
- Write request is stable: `mem_addr`/`mem_data` do not change while `mem_we`=1 and `mem_ready`=0.

## Timing
- Reset values:
  - Outputs: `mem_addr`=0, `mem_data`=0, `mem_we`=0, `busy`=0, `overflow`=0, `level`=0.
  - Internal: FIFO empty, `clear_pending`=0, FSM in IDLE.
- Reset mid-operation discards all queued plots and any sweep in progress. No partial write is retried.
- Plot latency: a plot accepted in cycle N into an empty FIFO in IDLE gives `mem_we`=1 in cycle N+2 (N+1 FIFO write, N+2 FSM enters DRAIN with registered outputs).
- Throughput: with `mem_ready` held high, one write is accepted per cycle in both DRAIN and CLEAR.
- Sweep length: X_MAX*Y_MAX accepted writes, i.e. 19200 cycles minimum.
- `level` updates the cycle after a push or pop.
- `overflow` is set the cycle after the dropped plot and clears only on reset.

## Configuration
- `PLOT_CLIP_EN` defined:
  - A plot with `x>=X_MAX` or `y>=Y_MAX` is discarded at the input.
  - A discarded plot is not enqueued and does not set `overflow`.
- `PLOT_CLIP_EN` undefined: all plots are enqueued, and the address wraps per the truncation rule above.

## Structure
- Shared package `plot_pkg` holds:
  - constants `X_MAX`, `Y_MAX`, `ADDR_W`, `SCREEN_PIXELS`
  - state enum `plot_state_t` {IDLE, DRAIN, CLEAR}
  - struct `pixel_t` {x[7:0], y[7:0], color[2:0]}
- One sub-module, `pixel_fifo`: synchronous FIFO of `pixel_t`, DEPTH entries, with push, pop, full, empty and level. FSM and address logic stay in `plot_sink`.

## Test plan
- Single plot with `mem_ready`=1: plot (x=10, y=5, color=3) in cycle 0 → `mem_we`=1 with `mem_addr`=810, `mem_data`=3 in cycle 2; `busy` low by cycle 4.
- Back-pressure: `mem_ready`=0 for 5 cycles after 3 plots → `mem_addr`/`mem_data` held stable; on release, the writes occur in order on 3 consecutive cycles.
- Overflow: 10 back-to-back plots with `mem_ready`=0 and DEPTH=8 → `level`=8, `overflow`=1; after release, exactly the first 8 pixels are written.
- Clear: `clear` with color=5 and `mem_ready`=1 → 19200 writes to addresses 0..19199, all data 5; a plot issued mid-sweep is written once, after address 19199.
- Clip: with `PLOT_CLIP_EN` defined, plot (x=160, y=0) → no write, `overflow`=0. With it undefined → write to address 160.
- Reset mid-sweep: assert `reset_n`=0 at sweep address 100 → next cycle `mem_we`=0, `level`=0, `busy`=0, and no further writes occur.
